div_request_sequencer: RTL and testbench

//  Upstream front-end for the 24-bit iterative restoring divider. Accepts tagged

---
 rtl/div_request_sequencer.sv | 116 +++++++++++
 tb/tb_div_request_sequencer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_request_sequencer.sv
// Front-end for the iterative divider: accepts tagged requests, screens divide-by-zero,
// pulses div_start, waits for done under a watchdog, and returns the result over valid/ready.
module div_request_sequencer #(
    parameter int WIDTH   = 24,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 63
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_dividend,
    input  logic [WIDTH-1:0] in_divisor,
    input  logic [TAG_W-1:0] in_tag,
    output logic             div_start,
    output logic [WIDTH-1:0] div_dividend,
    output logic [WIDTH-1:0] div_divisor,
    input  logic [WIDTH-1:0] div_quotient,
    input  logic             div_done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quotient,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_dbz,
    output logic             out_timeout,
    output logic             busy
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        RESULT,
        RECOVER
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic             accept;
    logic             dbz_req;
    logic             timeout_hit;

    assign accept      = in_valid && (state == IDLE);
    assign dbz_req     = (in_divisor == '0);
    assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));

    assign in_ready  = (state == IDLE);
    assign div_start = (state == LAUNCH);
    assign out_valid = (state == RESULT);
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = dbz_req ? RESULT : LAUNCH;
            LAUNCH:  state_nxt = WAIT;
            // done takes priority over the watchdog when both land together
            WAIT:    if (div_done || timeout_hit) state_nxt = RESULT;
            RESULT:  if (out_ready) state_nxt = out_timeout ? RECOVER : IDLE;
            RECOVER: if (div_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_dividend <= '0;
            div_divisor  <= '0;
            out_quotient <= '0;
            out_tag      <= '0;
            out_dbz      <= 1'b0;
            out_timeout  <= 1'b0;
            wait_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        out_tag     <= in_tag;
                        out_dbz     <= dbz_req;
                        out_timeout <= 1'b0;
                        if (dbz_req) begin
                            out_quotient <= {WIDTH{1'b1}};
                        end else begin
                            div_dividend <= in_dividend;
                            div_divisor  <= in_divisor;
                        end
                    end
                end
                LAUNCH: wait_cnt <= '0;
                WAIT: begin
                    if (div_done) begin
                        out_quotient <= div_quotient;
                        out_dbz      <= 1'b0;
                        out_timeout  <= 1'b0;
                    end else if (timeout_hit) begin
                        out_quotient <= '0;
                        out_timeout  <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_div_request_sequencer.sv
// Bench for div_request_sequencer with a behavioural divider model and a result scoreboard.
module tb_div_request_sequencer;
    localparam int WIDTH   = 24;
    localparam int TAG_W   = 4;
    localparam int TIMEOUT = 63;
    localparam int DIV_LAT = 26;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_dividend;
    logic [WIDTH-1:0] in_divisor;
    logic [TAG_W-1:0] in_tag;
    logic             div_start;
    logic [WIDTH-1:0] div_dividend;
    logic [WIDTH-1:0] div_divisor;
    logic [WIDTH-1:0] div_quotient;
    logic             div_done;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_quotient;
    logic [TAG_W-1:0] out_tag;
    logic             out_dbz;
    logic             out_timeout;
    logic             busy;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic [TAG_W-1:0] tag;
        logic             dbz;
        logic             to;
    } exp_t;

    exp_t sb[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   start_cnt = 0;

    logic             stub_hang  = 1'b0;
    logic             force_done = 1'b0;
    logic             m_done;
    logic             m_busy;
    int               m_cnt;
    logic [WIDTH-1:0] m_a;
    logic [WIDTH-1:0] m_b;
    logic [WIDTH-1:0] m_q;

    always #5 clk = ~clk;

    div_request_sequencer #(.WIDTH(WIDTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_dividend(in_dividend), .in_divisor(in_divisor), .in_tag(in_tag),
        .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_quotient(div_quotient), .div_done(div_done),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_quotient(out_quotient), .out_tag(out_tag),
        .out_dbz(out_dbz), .out_timeout(out_timeout), .busy(busy)
    );

    // Divider model: done is a level that drops on start and rises DIV_LAT cycles later.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_done <= 1'b0;
            m_busy <= 1'b0;
            m_cnt  <= 0;
            m_a    <= '0;
            m_b    <= '0;
            m_q    <= '0;
        end else if (div_start) begin
            m_done <= 1'b0;
            m_busy <= 1'b1;
            m_cnt  <= DIV_LAT;
            m_a    <= div_dividend;
            m_b    <= div_divisor;
        end else if (m_busy && !stub_hang) begin
            if (m_cnt == 1) begin
                m_done <= 1'b1;
                m_busy <= 1'b0;
                m_q    <= (m_b == 0) ? {WIDTH{1'b1}} : m_a / m_b;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    assign div_done     = m_done | force_done;
    assign div_quotient = m_q;

    always @(negedge clk) if (div_start) start_cnt++;

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [TAG_W-1:0] t, input logic expect_to);
        exp_t e;
        int   cyc = 0;
        in_valid    = 1'b1;
        in_dividend = a;
        in_divisor  = b;
        in_tag      = t;
        while (!in_ready && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        total_cnt++;
        if (!in_ready) begin
            $display("FAIL send_accept: in_ready=%0b after %0d cycles, required 1", in_ready, cyc);
            in_valid = 1'b0;
            return;
        end
        pass_cnt++;
        e.tag = t;
        e.dbz = (b == 0);
        e.to  = expect_to;
        e.q   = (b == 0) ? {WIDTH{1'b1}} : (expect_to ? '0 : a / b);
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic collect(input string name, input int hold, output int lat);
        exp_t e;
        int   cyc = 0;
        while (!out_valid && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        lat = cyc;
        total_cnt++;
        if (!out_valid) begin
            $display("FAIL %s_valid: out_valid=0 after %0d cycles, required 1", name, cyc);
            return;
        end
        pass_cnt++;
        total_cnt++;
        if (sb.size() == 0) begin
            $display("FAIL %s_sb: result q=%0h with empty scoreboard, required none", name, out_quotient);
            return;
        end
        pass_cnt++;
        e = sb.pop_front();
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            total_cnt++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_quotient !== e.q || out_tag !== e.tag)
                $display("FAIL %s_hold%0d: valid=%0b rdy=%0b q=%0h tag=%0h, required 1 0 %0h %0h",
                         name, i, out_valid, in_ready, out_quotient, out_tag, e.q, e.tag);
            else pass_cnt++;
        end
        out_ready = 1'b1;
        total_cnt++;
        if (out_quotient !== e.q) $display("FAIL %s_q: got %0h, required %0h", name, out_quotient, e.q);
        else pass_cnt++;
        total_cnt++;
        if (out_tag !== e.tag) $display("FAIL %s_tag: got %0h, required %0h", name, out_tag, e.tag);
        else pass_cnt++;
        total_cnt++;
        if (out_dbz !== e.dbz) $display("FAIL %s_dbz: got %0b, required %0b", name, out_dbz, e.dbz);
        else pass_cnt++;
        total_cnt++;
        if (out_timeout !== e.to) $display("FAIL %s_timeout: got %0b, required %0b", name, out_timeout, e.to);
        else pass_cnt++;
        @(negedge clk);
        out_ready = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL %s_drop: out_valid=%0b after handshake, required 0", name, out_valid);
        else pass_cnt++;
    endtask

    task automatic check_reset_outputs(input string name);
        total_cnt++;
        if (div_start !== 1'b0 || out_valid !== 1'b0 || out_dbz !== 1'b0 || out_timeout !== 1'b0 ||
            busy !== 1'b0 || div_dividend !== '0 || div_divisor !== '0 || out_quotient !== '0 || out_tag !== '0)
            $display("FAIL %s: start=%0b valid=%0b dbz=%0b to=%0b busy=%0b dd=%0h dv=%0h q=%0h tag=%0h, required all 0",
                     name, div_start, out_valid, out_dbz, out_timeout, busy, div_dividend, div_divisor,
                     out_quotient, out_tag);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_state");
        reset = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b, required 1", in_ready);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        int s0 = start_cnt;
        int lat;
        send(24'd100, 24'd7, 4'd3, 1'b0);
        collect("basic", 0, lat);
        total_cnt++;
        if (lat !== DIV_LAT + 2) $display("FAIL basic_latency: got %0d, required %0d", lat, DIV_LAT + 2);
        else pass_cnt++;
        total_cnt++;
        if (start_cnt - s0 !== 1) $display("FAIL basic_start_pulses: got %0d, required 1", start_cnt - s0);
        else pass_cnt++;
    endtask

    task automatic test_dbz();
        int s0 = start_cnt;
        int lat;
        send(24'h123456, 24'd0, 4'd5, 1'b0);
        total_cnt++;
        if (out_valid !== 1'b1) $display("FAIL dbz_next_cycle: out_valid=%0b, required 1", out_valid);
        else pass_cnt++;
        collect("dbz", 0, lat);
        total_cnt++;
        if (start_cnt - s0 !== 0) $display("FAIL dbz_no_start: got %0d pulses, required 0", start_cnt - s0);
        else pass_cnt++;
    endtask

    task automatic test_hold();
        int lat;
        send(24'd1000, 24'd10, 4'd7, 1'b0);
        collect("hold", 10, lat);
    endtask

    task automatic test_back_to_back();
        int lat;
        send(24'd50, 24'd5, 4'd1, 1'b0);
        collect("b2b_1", 0, lat);
        send(24'd9, 24'd3, 4'd2, 1'b0);
        collect("b2b_2", 0, lat);
        total_cnt++;
        if (lat !== DIV_LAT + 2) $display("FAIL b2b_stale_done: latency %0d, required %0d", lat, DIV_LAT + 2);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        int lat;
        stub_hang = 1'b1;
        send(24'd77, 24'd7, 4'd6, 1'b1);
        collect("timeout", 0, lat);
        total_cnt++;
        if (lat !== TIMEOUT + 1) $display("FAIL timeout_latency: got %0d, required %0d", lat, TIMEOUT + 1);
        else pass_cnt++;
        repeat (4) @(negedge clk);
        total_cnt++;
        if (in_ready !== 1'b0 || busy !== 1'b1)
            $display("FAIL recover_hold: in_ready=%0b busy=%0b, required 0 1", in_ready, busy);
        else pass_cnt++;
        force_done = 1'b1;
        @(negedge clk);
        force_done = 1'b0;
        stub_hang  = 1'b0;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL recover_exit: in_ready=%0b, required 1", in_ready);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int lat;
        send(24'd100, 24'd7, 4'd9, 1'b0);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_outputs("midreset_state");
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL midreset_in_ready: got %0b, required 1", in_ready);
        else pass_cnt++;
        send(24'd100, 24'd7, 4'd4, 1'b0);
        collect("after_reset", 0, lat);
    endtask

    initial begin
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_dividend = '0;
        in_divisor  = '0;
        in_tag      = '0;
        out_ready   = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_dbz();
        test_hold();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
